// File: rtl/bf_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bf_mem_arbiter
// Purpose  : Shares the single-ported program/data memory between the BF core
//            and the host port. Each access runs IDLE -> ACCESS -> DONE, with
//            WAIT_CYCLES extra memory latency cycles. Simultaneous requests are
//            resolved round-robin. host_hold blocks new core grants while a
//            program is being loaded.
// Ports    :
//   clk, reset                       clock, synchronous active-high reset
//   core_req/we/addr/wdata           core request handshake (level request)
//   core_rdata, core_ack             core read data (registered), done pulse
//   host_req/we/addr/wdata           host request handshake (level request)
//   host_rdata, host_ack             host read data (registered), done pulse
//   host_hold                        blocks new core grants while high
//   mem_addr/wdata/we/oe, mem_rdata  memory interface
//   busy                             high in ACCESS and DONE
//   owner                            requester of current/last grant (1=host)
// Revision : 1.0  initial release
// ============================================================================
module bf_mem_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_ack,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    input  logic              host_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    // Wait-state counter is 4 bits wide; only 0..15 is meaningful.
    localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_wait;
    logic       r_we;
    logic       r_last_host;   // 1 = last grant went to host

    logic w_host_elig;
    logic w_core_elig;
    logic w_any_elig;
    logic w_grant_host;

    // Host is never blocked; core is blocked by host_hold. On a tie the
    // requester that did not win last time is granted.
    assign w_host_elig  = host_req;
    assign w_core_elig  = core_req && !host_hold;
    assign w_any_elig   = w_host_elig || w_core_elig;
    assign w_grant_host = w_host_elig && (!w_core_elig || !r_last_host);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait      <= 4'd0;
            r_we        <= 1'b0;
            r_last_host <= 1'b0;
            core_rdata  <= '0;
            core_ack    <= 1'b0;
            host_rdata  <= '0;
            host_ack    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            busy        <= 1'b0;
            owner       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    core_ack <= 1'b0;
                    host_ack <= 1'b0;
                    if (w_any_elig) begin
                        owner       <= w_grant_host;
                        r_last_host <= w_grant_host;
                        if (w_grant_host) begin
                            r_we      <= host_we;
                            mem_addr  <= host_addr;
                            mem_wdata <= host_wdata;
                            mem_we    <= host_we;
                            mem_oe    <= !host_we;
                        end else begin
                            r_we      <= core_we;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                            mem_we    <= core_we;
                            mem_oe    <= !core_we;
                        end
                        busy    <= 1'b1;
                        r_wait  <= c_WAIT_INIT;
                        r_state <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (r_wait == 4'd0) begin
                        // Last access cycle: capture read data into the
                        // owner's register and raise its ack for DONE.
                        mem_we <= 1'b0;
                        mem_oe <= 1'b0;
                        if (owner) begin
                            host_ack <= 1'b1;
                            if (!r_we) begin
                                host_rdata <= mem_rdata;
                            end
                        end else begin
                            core_ack <= 1'b1;
                            if (!r_we) begin
                                core_rdata <= mem_rdata;
                            end
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end

                S_DONE: begin
                    core_ack <= 1'b0;
                    host_ack <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end

                default: begin
                    core_ack <= 1'b0;
                    host_ack <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_oe   <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/bf_mem_arbiter.md
Name: bf_mem_arbiter

Overview:
- Shares the processor's single-ported program/data memory between two requesters: the BF core and a host port used for program loading, tape inspection and debug.
- The core FSM gets one request/ack handshake for both instruction fetch and data read/write; the host gets an identical one.
- The arbiter sequences each memory access, including configurable wait states, and enforces round-robin fairness.
- A host hold input freezes core access while a program is being loaded.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
WAIT_CYCLES, 1, extra memory latency cycles per access (0..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_req  in  1  core access request (level, held until core_ack)
core_we  in  1  1 = write, 0 = read
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_rdata  out  DATA_W  core read data, registered
core_ack  out  1  one-cycle completion pulse
host_req  in  1  host access request
host_we  in  1  host write enable
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  host read data, registered
host_ack  out  1  one-cycle completion pulse
host_hold  in  1  blocks new core grants while high
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_oe  out  1  memory read enable
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in ACCESS and DONE
owner  out  1  requester of the current/last grant (1 = host)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: all outputs 0, state IDLE, last_grant = core (so host wins the first tie).
- States: IDLE -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Eligible requesters: host if host_req; core if core_req && !host_hold.
  - One eligible: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: latch we/addr/wdata from the granted port into mem_addr/mem_wdata; set owner and last_grant; go to ACCESS with wait counter = WAIT_CYCLES.
- ACCESS:
  - Lasts WAIT_CYCLES+1 cycles. mem_addr and mem_wdata are stable throughout.
  - mem_we = latched we; mem_oe = !latched we.
  - On the last ACCESS cycle, a read captures mem_rdata into the owner's rdata register; the other port's rdata is unchanged.
  - Then go to DONE.
- DONE:
  - Owner's ack = 1 for exactly one cycle; mem_we = mem_oe = 0; go to IDLE.
  - rdata stays valid from the DONE cycle until that port's next read completes.
- Latency: req high in an IDLE cycle N gives ack in cycle N+WAIT_CYCLES+2. Back-to-back throughput is one access per WAIT_CYCLES+3 cycles, because IDLE is always visited.
- Requester rules:
  - Request fields must be stable while req is high.
  - Requester drops req on the edge where it sees ack, so req is low in the following IDLE cycle. A req still high then is a new request.
- Requests are never aborted once granted. host_hold rising during a core ACCESS lets that access complete and ack normally.
- host_hold only blocks core; host requests are unaffected. While hold is high and host idle, the arbiter sits in IDLE.
- core_ack and host_ack are never high in the same cycle.
- Reset mid-operation: at the next edge go to IDLE with mem_we/mem_oe = 0, no ack issued, rdata registers cleared, last_grant = core.
- WAIT_CYCLES counter width is 4 bits. Values above 15 are illegal; the implementation may assert on them.

Test Plan:
- Core read: WAIT_CYCLES=1, core_req at cycle 0, addr 0x05, mem_rdata=0x2B -> mem_oe high cycles 1-2 with mem_addr=0x05, mem_we never high, core_ack pulse cycle 3, core_rdata=0x2B, host_ack stays 0.
- Host write: addr 0x10, wdata 0x5B ("[") -> mem_we high cycles 1-2 with mem_addr=0x10, mem_wdata=0x5B; host_ack at cycle 3; owner=1; core_rdata unchanged.
- Fairness: after reset, core_req and host_req both high and re-issued after each ack -> grants host, core, host, core; owner toggles; no requester waits more than one access.
- Hold: host_hold=1 with core_req high for 20 cycles -> no core_ack. A host write to 0x00 in that window completes. Drop hold at cycle 20 -> core granted in the first IDLE cycle, ack WAIT_CYCLES+2 cycles later.
- Reset mid-write: reset during host write ACCESS cycle 1 -> cycle after: mem_we=0, busy=0, no host_ack, rdata=0. Next simultaneous request is granted to host.
- WAIT_CYCLES=0 back-to-back core reads 0x00, 0x01 -> acks at cycles 2 and 5, rdata matches memory model each time.
